// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction prefetch queue with 1-cycle memory reads and redirect flush
// Define IFQ_BYPASS_EN to forward a response straight to the core when the queue is empty.
module ifetch_queue #(
  parameter int            DEPTH    = 4,
  parameter int            AW       = 8,
  parameter int            DW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_rd,
  output logic [AW-1:0]            mem_addr,
  input  logic [DW-1:0]            mem_data,
  output logic                     q_valid,
  output logic [DW-1:0]            q_data,
  output logic [AW-1:0]            q_pc,
  input  logic                     core_ready,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] fpc;
  logic [AW-1:0] tag;
  logic          inflight;
  logic [CW-1:0] cnt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [DW-1:0] data_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];

  logic [CW:0]   credit;
  logic          resp_valid;
  logic          head_valid;
  logic          bypass;
  logic          bypass_take;
  logic          push;
  logic          pop;

  // Issue only depends on registered state, so core_ready never reaches mem_rd.
  always_comb begin
    credit      = {1'b0, cnt} + {{CW{1'b0}}, inflight};
    mem_rd      = rst & ~redirect & (credit < (CW+1)'(DEPTH));
    mem_addr    = fpc;
    resp_valid  = rst & inflight & ~redirect;
    head_valid  = rst & (cnt != '0);
`ifdef IFQ_BYPASS_EN
    bypass      = resp_valid & (cnt == '0);
`else
    bypass      = 1'b0;
`endif
    bypass_take = bypass & core_ready;
    push        = resp_valid & ~bypass_take;
    pop         = head_valid & core_ready & ~redirect;
    q_valid     = head_valid | bypass;
    q_data      = '0;
    q_pc        = '0;
    if (head_valid) begin
      q_data = data_mem[rd_ptr];
      q_pc   = pc_mem[rd_ptr];
    end else if (bypass) begin
      q_data = mem_data;
      q_pc   = tag;
    end
    count       = cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fpc      <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect) begin
      fpc      <= redirect_pc;
      inflight <= 1'b0;
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= mem_rd;
      if (mem_rd) begin
        fpc <= fpc + AW'(1);
        tag <= fpc;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the head is only exposed when cnt is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= mem_data;
      pc_mem[wr_ptr]   <= tag;
    end
  end

endmodule
